// File: rtl/loom_arith_pkg.sv
// Shared helpers for the pipelined arith shifters.
// Stage count and the mask of shift bits that force a zero result.
package loom_arith_pkg;

  function automatic int shift_stages(input int w);
    int s;
    s = 0;
    for (int i = 0; i < 7; i++)
      if ((1 << i) < w) s = i + 1;
    return s;
  endfunction

  function automatic logic [63:0] zero_mask(input int w);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 64; i++)
      if (i >= shift_stages(w) && i < w) m[i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/arith_shli_stage.sv
// One barrel-shifter stage: elastic register with a
// conditional constant left shift applied on load.
module arith_shli_stage #(
  parameter int WIDTH = 32,
  parameter int SHIFT = 1,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    in_amt,
  input  logic             in_zero,
  input  logic             shift_en,
  input  logic             next_load,
  output logic             load,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [AW-1:0]    amt,
  output logic             zero
);

  assign load = ~valid | next_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      amt   <= '0;
      zero  <= 1'b0;
    end else if (load) begin
      valid <= in_valid;
      data  <= shift_en ? (in_data << SHIFT) : in_data;
      amt   <= in_amt;
      zero  <= in_zero;
    end
  end

endmodule

// File: rtl/arith_shli_pipe.sv
// Pipelined logical left shift with a joined a/b handshake.
// One registered stage per shift-amount bit.
module arith_shli_pipe
  import loom_arith_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] b_data,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result_data
);

  localparam int STAGES = shift_stages(WIDTH);
  localparam logic [63:0] ZM = zero_mask(WIDTH);
  localparam logic [STAGES:0] WLIM = (STAGES+1)'(WIDTH);

  logic [STAGES-1:0] b_amt;
  logic              entry_zero;
  logic              in_ready;

  logic              ld  [STAGES];
  logic              nxt [STAGES];
  logic [STAGES-1:0] v, z, iv, iz, ise;
  logic [STAGES-1:0][WIDTH-1:0]  d, id;
  logic [STAGES-1:0][STAGES-1:0] am, ia;
  logic [STAGES-1:0] unused_amt;

  assign b_amt = b_data[STAGES-1:0];

  // amounts in [WIDTH, 2^STAGES) only occur for non-power-of-two widths
  assign entry_zero = (|(b_data & ZM[WIDTH-1:0]))
                    | ({1'b0, b_amt} >= WLIM);

  assign in_ready = ld[0];
  assign a_ready  = in_ready & b_valid;
  assign b_ready  = in_ready & a_valid;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign iv[k]  = a_valid & b_valid;
      assign id[k]  = a_data;
      assign ia[k]  = b_amt;
      assign iz[k]  = entry_zero;
      assign ise[k] = b_amt[0];
    end else begin : g_mid
      assign iv[k]  = v[k-1];
      assign id[k]  = d[k-1];
      assign ia[k]  = am[k-1];
      assign iz[k]  = z[k-1];
      assign ise[k] = am[k-1][k];
    end

    if (k == STAGES-1) begin : g_last
      assign nxt[k] = result_ready;
    end else begin : g_chain
      assign nxt[k] = ld[k+1];
    end

    arith_shli_stage #(
      .WIDTH (WIDTH),
      .SHIFT (1 << k),
      .AW    (STAGES)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv[k]),
      .in_data   (id[k]),
      .in_amt    (ia[k]),
      .in_zero   (iz[k]),
      .shift_en  (ise[k]),
      .next_load (nxt[k]),
      .load      (ld[k]),
      .valid     (v[k]),
      .data      (d[k]),
      .amt       (am[k]),
      .zero      (z[k])
    );
  end

  assign unused_amt   = am[STAGES-1];
  assign result_valid = v[STAGES-1];
  assign result_data  = z[STAGES-1] ? '0 : d[STAGES-1];

endmodule

// File: tb/tb_arith_shli_pipe.sv
// Scoreboard bench for arith_shli_pipe at WIDTH=32.
// Scenario tasks run in sequence; a negedge monitor checks the stream.
module tb_arith_shli_pipe;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         a_valid = 1'b0, b_valid = 1'b0;
  logic         a_ready, b_ready;
  logic [W-1:0] a_data = '0, b_data = '0;
  logic         result_valid;
  logic         result_ready = 1'b1;
  logic [W-1:0] result_data;

  int vectors = 0;
  int errs    = 0;
  int n_fire  = 0;
  logic [W-1:0] q[$];
  logic [W-1:0] sb_exp;

  arith_shli_pipe #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .a_valid      (a_valid),
    .a_ready      (a_ready),
    .a_data       (a_data),
    .b_valid      (b_valid),
    .b_ready      (b_ready),
    .b_data       (b_data),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_data  (result_data)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    if (b >= W) return '0;
    return a << b;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if ((a_valid && a_ready) != (b_valid && b_ready)) begin
        errs++;
        $display("FAIL join: a_fire=%0b b_fire=%0b, required equal",
                 a_valid && a_ready, b_valid && b_ready);
      end
      if (result_valid && result_ready) begin
        vectors++;
        if (q.size() == 0) begin
          errs++;
          $display("FAIL stream: got %h, required no result", result_data);
        end else begin
          sb_exp = q.pop_front();
          if (result_data !== sb_exp) begin
            errs++;
            $display("FAIL stream: got %h, required %h", result_data, sb_exp);
          end
        end
      end
      if (a_valid && b_valid && a_ready && b_ready) begin
        q.push_back(model(a_data, b_data));
        n_fire++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    a_valid = 0;
    b_valid = 0;
    result_ready = 1;
    n = 0;
    while ((q.size() != 0 || result_valid) && n < 60) begin
      tick();
      n++;
    end
    vectors++;
    if (q.size() != 0 || result_valid) begin
      errs++;
      $display("FAIL %s drain: %0d left, required 0", name, q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (result_valid !== 1'b0 || result_data !== '0) begin
      errs++;
      $display("FAIL reset: valid=%b data=%h, required 0/0",
               result_valid, result_data);
    end
    vectors++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      errs++;
      $display("FAIL reset_ready: a=%b b=%b, required 0/0", a_ready, b_ready);
    end
    @(negedge clk);
    rst = 0;
    tick();
  endtask

  task automatic test_latency(input string name, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic [W-1:0] exp);
    int bad;
    result_ready = 1;
    a_data  = a;
    b_data  = b;
    a_valid = 1;
    b_valid = 1;
    @(negedge clk);
    vectors++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
      errs++;
      $display("FAIL %s accept: a_ready=%b b_ready=%b, required 1/1",
               name, a_ready, b_ready);
    end
    tick();
    a_valid = 0;
    b_valid = 0;
    bad = 0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (result_valid !== (i == 5)) bad++;
      if (i == 5) begin
        vectors++;
        if (result_data !== exp) begin
          errs++;
          $display("FAIL %s data: got %h, required %h", name, result_data, exp);
        end
      end
    end
    vectors++;
    if (bad != 0) begin
      errs++;
      $display("FAIL %s latency: %0d wrong cycles, required 0", name, bad);
    end
    tick();
  endtask

  task automatic test_boundaries();
    test_latency("b31", 32'h3, 32'd31, 32'h8000_0000);
    test_latency("b32", 32'hFFFF_FFFF, 32'd32, 32'h0);
    test_latency("ball", 32'h1234_5678, 32'hFFFF_FFFF, 32'h0);
    test_latency("b0", 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF);
    test_latency("b33", 32'hFFFF_FFFF, 32'd33, 32'h0);
    test_latency("b17", 32'h0000_ABCD, 32'd17, 32'h579A_0000);
  endtask

  task automatic test_backpressure();
    int idx, acc, gaps;
    result_ready = 0;
    idx = 0;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      a_valid = 1;
      b_valid = 1;
      a_data  = 32'h100 + idx;
      b_data  = idx;
      @(negedge clk);
      if (a_ready && b_ready) begin
        acc++;
        idx++;
      end
      tick();
    end
    vectors++;
    if (acc != 5) begin
      errs++;
      $display("FAIL bp_accept: got %0d, required 5", acc);
    end
    @(negedge clk);
    vectors++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0 || result_valid !== 1'b1) begin
      errs++;
      $display("FAIL bp_full: a=%b b=%b rv=%b, required 0/0/1",
               a_ready, b_ready, result_valid);
    end
    tick();
    result_ready = 1;
    gaps = 0;
    for (int c = 0; c < 8; c++) begin
      a_valid = (idx < 8);
      b_valid = (idx < 8);
      a_data  = 32'h100 + idx;
      b_data  = idx;
      @(negedge clk);
      if (!result_valid) gaps++;
      if (a_valid && a_ready && b_ready) idx++;
      tick();
    end
    vectors++;
    if (gaps != 0 || idx != 8) begin
      errs++;
      $display("FAIL bp_release: gaps=%0d ops=%0d, required 0/8", gaps, idx);
    end
    drain("bp");
  endtask

  task automatic test_join();
    int bad, f0;
    result_ready = 1;
    f0 = n_fire;
    bad = 0;
    a_valid = 1;
    b_valid = 0;
    a_data  = 32'h55;
    b_data  = 32'd2;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (a_ready !== 1'b0) bad++;
      tick();
    end
    vectors++;
    if (bad != 0 || n_fire != f0) begin
      errs++;
      $display("FAIL join_hold: ready_high=%0d fired=%0d, required 0/0",
               bad, n_fire - f0);
    end
    b_valid = 1;
    @(negedge clk);
    vectors++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
      errs++;
      $display("FAIL join_both: a=%b b=%b, required 1/1", a_ready, b_ready);
    end
    tick();
    drain("join");
  endtask

  task automatic test_reset_inflight();
    int f0, n, stale;
    result_ready = 0;
    f0 = n_fire;
    for (int i = 0; i < 3; i++) begin
      a_valid = 1;
      b_valid = 1;
      a_data  = 32'hF0 + i;
      b_data  = i + 1;
      tick();
    end
    a_valid = 0;
    b_valid = 0;
    n = 0;
    while (!result_valid && n < 10) begin
      tick();
      n++;
    end
    vectors++;
    if (!result_valid || n_fire - f0 != 3) begin
      errs++;
      $display("FAIL rst_fill: rv=%b fired=%0d, required 1/3",
               result_valid, n_fire - f0);
    end
    #2 rst = 1;
    #1;
    vectors++;
    if (result_valid !== 1'b0 || result_data !== '0) begin
      errs++;
      $display("FAIL rst_async: valid=%b data=%h, required 0/0",
               result_valid, result_data);
    end
    q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    tick();
    result_ready = 1;
    stale = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (result_valid) stale++;
      tick();
    end
    vectors++;
    if (stale != 0) begin
      errs++;
      $display("FAIL rst_stale: %0d results, required 0", stale);
    end
    test_latency("post_rst", 32'h0000_0007, 32'd8, 32'h0000_0700);
  endtask

  task automatic test_random();
    int f0, cyc;
    f0 = n_fire;
    cyc = 0;
    while (n_fire - f0 < 10000 && cyc < 60000) begin
      a_valid = ($urandom % 4) != 0;
      b_valid = ($urandom % 4) != 0;
      result_ready = ($urandom % 4) != 0;
      a_data  = $urandom;
      case ($urandom % 8)
        0: b_data = $urandom;
        1: b_data = 32'hFFFF_FFFF;
        default: b_data = $urandom_range(0, 35);
      endcase
      tick();
      cyc++;
    end
    vectors++;
    if (n_fire - f0 < 10000) begin
      errs++;
      $display("FAIL random_count: got %0d ops, required 10000", n_fire - f0);
    end
    drain("random");
  endtask

  initial begin
    test_reset();
    test_latency("basic", 32'h1, 32'd4, 32'h10);
    test_boundaries();
    test_backpressure();
    test_join();
    test_reset_inflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
